ecc_sed_stream_encoder: RTL and testbench
=========================================

# ecc_sed_stream_encoder

Parametrised single-error-detect (SED) encoder for streaming datapaths. Splits each data word into `NUM_LANES` equal lanes and appends one parity bit per lane. Adds a valid/ready handshake with a 2-entry skid buffer, one-shot parity error injection for fault-path testing, and a saturating count of emitted words. Sits between a producer and any SED-protected storage or link, as the next-generation replacement for the fixed 12-bit combinational SED encoder.

## Interface
- `DATA_WIDTH`, 12: payload width in bits. Must be divisible by `NUM_LANES`; otherwise elaboration fails.
- `NUM_LANES`, 1: number of parity lanes. Lane width is `LW = DATA_WIDTH/NUM_LANES`.
- `ODD_PARITY`, 1: 1 selects odd parity (parity = ~^lane); 0 selects even parity (parity = ^lane).
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `data_valid` input 1: producer word valid.
- `data_ready` output 1: encoder can accept a word.
- `data` input DATA_WIDTH: payload.
- `enc_valid` output 1: codeword valid.
- `enc_ready` input 1: consumer accepts the codeword.
- `enc_codeword` output DATA_WIDTH+NUM_LANES: `{parity[NUM_LANES-1:0], data}`. `parity[i]` covers `data[i*LW +: LW]`.
- `inj_req` input 1: pulse that arms parity injection.
- `inj_mask` input NUM_LANES: parity bits to flip. Sampled when `inj_req`=1.
- `inj_pending` output 1: injection is armed and not yet applied.
- `cnt_clr` input 1: synchronous clear of `word_cnt`.
- `word_cnt` output 16: saturating count of output handshakes.

## Operation
- Accept: `data_valid && data_ready` in cycle N.
  - Parity is computed combinationally on `data`, then XORed with the armed mask if injection is pending.
  - The resulting codeword is written into the output register, or into the skid entry if the output register is occupied and not draining.
- Output register: holds the codeword with `enc_valid`=1 until `enc_valid && enc_ready`.
  - `enc_codeword` must be stable while `enc_valid && !enc_ready`.
- Skid buffer: one entry behind the output register.
  - `data_ready` is registered and equals "skid entry empty".
  - On output handshake with the skid full, the skid entry moves into the output register in the same edge.
- Injection:
  - `inj_req` loads `inj_mask` and sets `inj_pending`.
  - The mask is applied to exactly one accepted word, then `inj_pending` clears.
  - `inj_req` in the same cycle as an accept applies the new mask to that word; `inj_pending` stays 0.
  - `inj_req` while already pending overwrites the mask; the latest mask wins.
  - `inj_mask`=0 with `inj_req` arms a no-op injection; it is still consumed by one word.
- Counter:
  - `word_cnt` increments on each output handshake and saturates at 0xFFFF.
  - `cnt_clr` has priority over an increment in the same cycle; the result is 0.
- Reset (async assert, any time, including mid-transfer):
  - Outputs: `enc_valid`=0, `enc_codeword`=0, `data_ready`=1, `inj_pending`=0, `word_cnt`=0.
  - Skid entry and injection mask are cleared.
  - In-flight words are discarded.

## Timing
- Latency: a word accepted at edge N presents `enc_valid` from cycle N+1.
- Throughput: 1 word/cycle with `enc_ready` held high; the skid stays empty.
- Backpressure: with `enc_ready`=0 and output full, at most one more word is accepted (into the skid); `data_ready` is 0 from the following cycle.
- Release: `enc_ready` rising drains the output register and loads the skid at the same edge; `data_ready` returns to 1 the cycle after the skid empties.
- No combinational path from `enc_ready` to `data_ready`.

## Structure
- Package `ecc_sed_pkg`:
  - lane-width function `lane_w(DATA_WIDTH, NUM_LANES)`
  - `CNT_W`=16 and `CNT_MAX` constants
  - codeword-width function
- Sub-module `ecc_sed_parity_lane`: combinational, parameter `LW` and `ODD_PARITY`, lane in, parity bit out. Generated `NUM_LANES` times.
- The top level holds the output register, skid entry, injection state and counter.

## Test plan
- Default params (12/1/odd): `data`=0x000 → `enc_codeword`=0x1000. `data`=0x001 → 0x0001. `enc_valid` one cycle after accept.
- `DATA_WIDTH`=12, `NUM_LANES`=2, `ODD_PARITY`=0: `data`=0x0C1 → `enc_codeword`=0x10C1 (14 bits).
- Back-to-back 8 words with `enc_ready`=0 from word 2 for 5 cycles:
  - exactly 1 word lands in the skid
  - `data_ready`=0 until drain
  - order preserved, no loss or duplication
  - `word_cnt`=8 at the end
- `inj_req` with `inj_mask`=1 while idle → `inj_pending`=1. The next word `data`=0x000 (default params) emits 0x0000. The following word is correct and `inj_pending`=0.
- Counter: force 0xFFFE, then 3 handshakes → stays at 0xFFFF. `cnt_clr` coincident with a handshake → 0.
- Assert `rst` low with both the output register and skid full and injection armed → all outputs at reset values immediately. After release, the first new word is encoded correctly with no injection.

Source files
------------

// File: rtl/ecc_sed_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ecc_sed_pkg
// Brief    : Shared widths, constants and sizing helpers for the SED encoder.
// Revision : 1.0 - initial release
// ============================================================================
package ecc_sed_pkg;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    function automatic int lane_w(input int data_width, input int num_lanes);
        return data_width / num_lanes;
    endfunction

    function automatic int codeword_w(input int data_width, input int num_lanes);
        return data_width + num_lanes;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ecc_sed_parity_lane.sv
`default_nettype none
// ============================================================================
// Module   : ecc_sed_parity_lane
// Brief    : Combinational odd/even parity over one data lane.
// Revision : 1.0 - initial release
// ============================================================================
module ecc_sed_parity_lane #(
    parameter int LW         = 12,
    parameter bit ODD_PARITY = 1'b1
) (
    input  logic [LW-1:0] lane,
    output logic          parity
);

    assign parity = ODD_PARITY ? ~^lane : ^lane;

endmodule
`default_nettype wire

// File: rtl/ecc_sed_stream_encoder.sv
`default_nettype none
// ============================================================================
// Module   : ecc_sed_stream_encoder
// Brief    : Streaming per-lane SED encoder with skid buffer, parity error
//            injection and saturating output word counter.
// Revision : 1.0 - initial release
// ============================================================================
module ecc_sed_stream_encoder
    import ecc_sed_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int NUM_LANES  = 1,
    parameter bit ODD_PARITY = 1'b1
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         data_valid,
    output logic                                         data_ready,
    input  logic [DATA_WIDTH-1:0]                        data,
    output logic                                         enc_valid,
    input  logic                                         enc_ready,
    output logic [codeword_w(DATA_WIDTH, NUM_LANES)-1:0] enc_codeword,
    input  logic                                         inj_req,
    input  logic [NUM_LANES-1:0]                         inj_mask,
    output logic                                         inj_pending,
    input  logic                                         cnt_clr,
    output logic [CNT_W-1:0]                             word_cnt
);

    localparam int LW = lane_w(DATA_WIDTH, NUM_LANES);
    localparam int CW = codeword_w(DATA_WIDTH, NUM_LANES);

    logic [NUM_LANES-1:0] w_lane_parity;
    logic [NUM_LANES-1:0] w_mask_eff;
    logic [NUM_LANES-1:0] w_parity;
    logic [CW-1:0]        w_codeword;
    logic                 w_accept;
    logic                 w_drain;
    logic                 w_inj_apply;

    logic                 r_out_valid;
    logic [CW-1:0]        r_out_cw;
    logic                 r_skid_valid;
    logic [CW-1:0]        r_skid_cw;
    logic                 r_data_ready;
    logic                 r_inj_pending;
    logic [NUM_LANES-1:0] r_inj_mask;
    logic [CNT_W-1:0]     r_word_cnt;

    if (DATA_WIDTH % NUM_LANES != 0) begin : g_width_check
        $error("DATA_WIDTH must be divisible by NUM_LANES");
    end

    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        ecc_sed_parity_lane #(
            .LW         (LW),
            .ODD_PARITY (ODD_PARITY)
        ) u_lane (
            .lane   (data[gi*LW +: LW]),
            .parity (w_lane_parity[gi])
        );
    end

    assign w_accept    = data_valid && r_data_ready;
    assign w_drain     = r_out_valid && enc_ready;
    // A request coincident with an accept applies its own mask directly.
    assign w_inj_apply = w_accept && (inj_req || r_inj_pending);
    assign w_mask_eff  = inj_req ? inj_mask : r_inj_mask;
    assign w_parity    = w_lane_parity ^ (w_inj_apply ? w_mask_eff : {NUM_LANES{1'b0}});
    assign w_codeword  = {w_parity, data};

    // data_ready tracks skid emptiness from a flop, so enc_ready never reaches it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid  <= 1'b0;
            r_out_cw     <= '0;
            r_skid_valid <= 1'b0;
            r_skid_cw    <= '0;
            r_data_ready <= 1'b1;
        end else if (!r_out_valid || w_drain) begin
            if (r_skid_valid) begin
                r_out_cw     <= r_skid_cw;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
                r_data_ready <= 1'b1;
            end else if (w_accept) begin
                r_out_cw    <= w_codeword;
                r_out_valid <= 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid_cw    <= w_codeword;
            r_skid_valid <= 1'b1;
            r_data_ready <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_inj_pending <= 1'b0;
            r_inj_mask    <= '0;
        end else if (w_accept) begin
            r_inj_pending <= 1'b0;
            r_inj_mask    <= '0;
        end else if (inj_req) begin
            r_inj_pending <= 1'b1;
            r_inj_mask    <= inj_mask;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_word_cnt <= '0;
        end else if (cnt_clr) begin
            r_word_cnt <= '0;
        end else if (w_drain && (r_word_cnt != CNT_MAX)) begin
            r_word_cnt <= r_word_cnt + 1'b1;
        end
    end

    assign data_ready   = r_data_ready;
    assign enc_valid    = r_out_valid;
    assign enc_codeword = r_out_cw;
    assign inj_pending  = r_inj_pending;
    assign word_cnt     = r_word_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ecc_sed_stream_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ecc_sed_stream_encoder
// Brief    : Scoreboard bench for the SED stream encoder (12/1/odd and 12/2/even).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ecc_sed_stream_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        data_valid;
    logic [11:0] data;
    logic        enc_ready;
    logic        inj_req;
    logic [0:0]  inj_mask;
    logic        cnt_clr;

    logic        data_ready, enc_valid, inj_pending;
    logic [12:0] enc_codeword;
    logic [15:0] word_cnt;

    logic        data_ready2, enc_valid2, inj_pending2;
    logic [13:0] enc_codeword2;
    logic [15:0] word_cnt2;

    int          errors = 0;
    int          checks = 0;
    logic [12:0] sb[$];

    always #5 clk = ~clk;

    ecc_sed_stream_encoder dut (
        .clk          (clk),
        .rst          (rst),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .data         (data),
        .enc_valid    (enc_valid),
        .enc_ready    (enc_ready),
        .enc_codeword (enc_codeword),
        .inj_req      (inj_req),
        .inj_mask     (inj_mask),
        .inj_pending  (inj_pending),
        .cnt_clr      (cnt_clr),
        .word_cnt     (word_cnt)
    );

    ecc_sed_stream_encoder #(
        .DATA_WIDTH (12),
        .NUM_LANES  (2),
        .ODD_PARITY (1'b0)
    ) dut2 (
        .clk          (clk),
        .rst          (rst),
        .data_valid   (data_valid),
        .data_ready   (data_ready2),
        .data         (data),
        .enc_valid    (enc_valid2),
        .enc_ready    (enc_ready),
        .enc_codeword (enc_codeword2),
        .inj_req      (1'b0),
        .inj_mask     (2'b00),
        .inj_pending  (inj_pending2),
        .cnt_clr      (cnt_clr),
        .word_cnt     (word_cnt2)
    );

    // Reference encoding for the default 12-bit, single-lane, odd-parity build.
    function automatic logic [12:0] enc12(input logic [11:0] d, input logic m);
        return {(~^d) ^ m, d};
    endfunction

    typedef struct packed {
        logic        req;
        logic        m;
        logic        dv;
        logic [11:0] d;
    } inj_step_t;

    task automatic test_reset;
        #12;
        checks++; if (enc_valid !== 1'b0) begin errors++; $display("FAIL reset_enc_valid: got %b expected 0", enc_valid); end
        checks++; if (enc_codeword !== 13'h0) begin errors++; $display("FAIL reset_codeword: got %h expected 0000", enc_codeword); end
        checks++; if (data_ready !== 1'b1) begin errors++; $display("FAIL reset_data_ready: got %b expected 1", data_ready); end
        checks++; if (inj_pending !== 1'b0) begin errors++; $display("FAIL reset_inj_pending: got %b expected 0", inj_pending); end
        checks++; if (word_cnt !== 16'h0) begin errors++; $display("FAIL reset_word_cnt: got %h expected 0000", word_cnt); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_encode_default;
        logic [11:0] words[2];
        logic [12:0] exp;
        words[0] = 12'h000;
        words[1] = 12'h001;
        enc_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            data_valid = 1'b1;
            data       = words[i];
            @(negedge clk);
            if (data_valid && data_ready) sb.push_back(enc12(data, 1'b0));
            @(posedge clk); #1;
            data_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (enc_valid !== 1'b1) begin
                errors++; $display("FAIL default_latency: enc_valid got %b expected 1", enc_valid);
            end else if (sb.size() == 0) begin
                errors++; $display("FAIL default_accept: word %0d not accepted, data_ready %b", i, data_ready);
            end else begin
                exp = sb.pop_front();
                if (enc_codeword !== exp) begin
                    errors++; $display("FAIL default_codeword: got %h expected %h", enc_codeword, exp);
                end
            end
            @(posedge clk); #1;
        end
        checks++;
        if (exp !== 13'h0001) begin errors++; $display("FAIL default_model: got %h expected 0001", exp); end
    endtask

    task automatic test_encode_lanes;
        enc_ready  = 1'b1;
        data_valid = 1'b1;
        data       = 12'h0C1;
        @(posedge clk); #1;
        data_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (enc_valid2 !== 1'b1 || enc_codeword2 !== 14'h10C1) begin
            errors++; $display("FAIL lanes_codeword: got valid=%b cw=%h expected valid=1 cw=10c1", enc_valid2, enc_codeword2);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        logic [11:0] words[8];
        logic [12:0] exp;
        int acc, max_occ;
        for (int i = 0; i < 8; i++) words[i] = 12'h100 + 12'(i * 37);
        data_valid = 1'b0;
        enc_ready  = 1'b0;
        cnt_clr    = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        acc     = 0;
        max_occ = 0;
        for (int t = 0; t < 60; t++) begin
            if (acc == 8 && sb.size() == 0) break;
            data_valid = (acc < 8);
            data       = words[(acc < 8) ? acc : 7];
            enc_ready  = !(t >= 1 && t < 6);
            @(negedge clk);
            checks++;
            if (data_ready !== 1'(sb.size() < 2)) begin
                errors++; $display("FAIL b2b_data_ready: cycle %0d got %b expected %b", t, data_ready, sb.size() < 2);
            end
            checks++;
            if (enc_valid !== 1'(sb.size() > 0)) begin
                errors++; $display("FAIL b2b_enc_valid: cycle %0d got %b expected %b", t, enc_valid, sb.size() > 0);
            end
            if (enc_valid && enc_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL b2b_extra_word: got %h expected none", enc_codeword);
                end else begin
                    exp = sb.pop_front();
                    if (enc_codeword !== exp) begin
                        errors++; $display("FAIL b2b_order: got %h expected %h", enc_codeword, exp);
                    end
                end
            end
            if (data_valid && data_ready) begin
                sb.push_back(enc12(data, 1'b0));
                acc++;
            end
            if (sb.size() > max_occ) max_occ = sb.size();
            @(posedge clk); #1;
        end
        data_valid = 1'b0;
        enc_ready  = 1'b1;
        checks++;
        if (acc != 8 || sb.size() != 0) begin
            errors++; $display("FAIL b2b_timeout: accepted %0d pending %0d expected 8 and 0", acc, sb.size());
            sb.delete();
        end
        checks++;
        if (max_occ != 2) begin errors++; $display("FAIL b2b_skid_depth: got %0d expected 2", max_occ); end
        @(negedge clk);
        checks++;
        if (word_cnt !== 16'd8) begin errors++; $display("FAIL b2b_word_cnt: got %0d expected 8", word_cnt); end
        @(posedge clk); #1;
    endtask

    task automatic test_inject;
        inj_step_t steps[12];
        logic      m_pend, m_mask;
        logic [12:0] exp;
        steps[0]  = '{1'b1, 1'b1, 1'b0, 12'h000};
        steps[1]  = '{1'b0, 1'b0, 1'b0, 12'h000};
        steps[2]  = '{1'b0, 1'b0, 1'b1, 12'h000};
        steps[3]  = '{1'b0, 1'b0, 1'b1, 12'h000};
        steps[4]  = '{1'b1, 1'b1, 1'b1, 12'h001};
        steps[5]  = '{1'b1, 1'b1, 1'b0, 12'h000};
        steps[6]  = '{1'b1, 1'b0, 1'b0, 12'h000};
        steps[7]  = '{1'b0, 1'b0, 1'b1, 12'h003};
        steps[8]  = '{1'b1, 1'b0, 1'b0, 12'h000};
        steps[9]  = '{1'b0, 1'b0, 1'b1, 12'h7FF};
        steps[10] = '{1'b0, 1'b0, 1'b1, 12'h7FF};
        steps[11] = '{1'b0, 1'b0, 1'b0, 12'h000};
        m_pend    = 1'b0;
        m_mask    = 1'b0;
        enc_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            inj_req    = steps[i].req;
            inj_mask   = steps[i].m;
            data_valid = steps[i].dv;
            data       = steps[i].d;
            @(negedge clk);
            checks++;
            if (inj_pending !== m_pend) begin
                errors++; $display("FAIL inj_pending: step %0d got %b expected %b", i, inj_pending, m_pend);
            end
            if (enc_valid && enc_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL inj_extra_word: got %h expected none", enc_codeword);
                end else begin
                    exp = sb.pop_front();
                    if (enc_codeword !== exp) begin
                        errors++; $display("FAIL inj_codeword: step %0d got %h expected %h", i, enc_codeword, exp);
                    end
                end
            end
            if (data_valid && data_ready) begin
                sb.push_back(enc12(data, (inj_req || m_pend) ? (inj_req ? inj_mask[0] : m_mask) : 1'b0));
                m_pend = 1'b0;
                m_mask = 1'b0;
            end else if (inj_req) begin
                m_pend = 1'b1;
                m_mask = inj_mask[0];
            end
            @(posedge clk); #1;
        end
        inj_req    = 1'b0;
        data_valid = 1'b0;
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL inj_lost_words: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_counter;
        int acc, hs;
        data       = 12'h000;
        enc_ready  = 1'b1;
        cnt_clr    = 1'b1;
        data_valid = 1'b0;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        acc = 0;
        hs  = 0;
        for (int phase = 0; phase < 2; phase++) begin
            int target;
            target = (phase == 0) ? 65534 : 65537;
            for (int t = 0; t < 70000 && hs < target; t++) begin
                data_valid = (acc < target);
                @(negedge clk);
                if (enc_valid && enc_ready) hs++;
                if (data_valid && data_ready) acc++;
                @(posedge clk); #1;
            end
            data_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (hs != target) begin
                errors++; $display("FAIL cnt_timeout: handshakes %0d expected %0d", hs, target);
            end
            checks++;
            if (word_cnt !== ((phase == 0) ? 16'hFFFE : 16'hFFFF)) begin
                errors++; $display("FAIL cnt_value: phase %0d got %h expected %h", phase, word_cnt,
                                   (phase == 0) ? 16'hFFFE : 16'hFFFF);
            end
            @(posedge clk); #1;
        end
        data_valid = 1'b1;
        enc_ready  = 1'b0;
        @(posedge clk); #1;
        data_valid = 1'b0;
        enc_ready  = 1'b1;
        cnt_clr    = 1'b1;
        @(negedge clk);
        checks++;
        if (enc_valid !== 1'b1) begin errors++; $display("FAIL cnt_clr_setup: enc_valid got %b expected 1", enc_valid); end
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        @(negedge clk);
        checks++;
        if (word_cnt !== 16'h0) begin errors++; $display("FAIL cnt_clr_priority: got %h expected 0000", word_cnt); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midflight;
        enc_ready  = 1'b0;
        data_valid = 1'b1;
        data       = 12'h0A0;
        @(posedge clk); #1;
        data = 12'h0A1;
        @(posedge clk); #1;
        data_valid = 1'b0;
        inj_req    = 1'b1;
        inj_mask   = 1'b1;
        @(posedge clk); #1;
        inj_req = 1'b0;
        checks++;
        if (data_ready !== 1'b0 || enc_valid !== 1'b1 || inj_pending !== 1'b1) begin
            errors++; $display("FAIL midrst_setup: got ready=%b valid=%b pend=%b expected 0 1 1",
                               data_ready, enc_valid, inj_pending);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (enc_valid !== 1'b0) begin errors++; $display("FAIL midrst_enc_valid: got %b expected 0", enc_valid); end
        checks++; if (enc_codeword !== 13'h0) begin errors++; $display("FAIL midrst_codeword: got %h expected 0000", enc_codeword); end
        checks++; if (data_ready !== 1'b1) begin errors++; $display("FAIL midrst_data_ready: got %b expected 1", data_ready); end
        checks++; if (inj_pending !== 1'b0) begin errors++; $display("FAIL midrst_inj_pending: got %b expected 0", inj_pending); end
        checks++; if (word_cnt !== 16'h0) begin errors++; $display("FAIL midrst_word_cnt: got %h expected 0000", word_cnt); end
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        enc_ready  = 1'b1;
        data_valid = 1'b1;
        data       = 12'h005;
        sb.push_back(enc12(12'h005, 1'b0));
        @(posedge clk); #1;
        data_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (enc_valid !== 1'b1 || enc_codeword !== sb[0]) begin
            errors++; $display("FAIL midrst_first_word: got valid=%b cw=%h expected valid=1 cw=%h",
                               enc_valid, enc_codeword, sb[0]);
        end
        sb.delete();
        @(posedge clk); #1;
    endtask

    initial begin
        rst        = 1'b0;
        data_valid = 1'b0;
        data       = 12'h000;
        enc_ready  = 1'b0;
        inj_req    = 1'b0;
        inj_mask   = 1'b0;
        cnt_clr    = 1'b0;
        test_reset();
        test_encode_default();
        test_encode_lanes();
        test_back_to_back();
        test_inject();
        test_counter();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
